// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: per-engine read requests and pixel responses.
// The master modport is a fetch engine group; the slave modport is the arbiter.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharer of the sprite ROM: 2-cycle request-to-pixel latency, one grant per cycle, no response backpressure.
// SPRITE_ARB_PRIO0_EN gives requester 0 strict priority; otherwise pure round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 4,
  parameter int ROM_DEPTH = 122880
) (
  input  logic               Clk,
  input  logic               Reset_n,
  sprite_rom_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               addr_err
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0]   NREQ  = (ID_W+1)'(NUM_REQ);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(ROM_DEPTH);

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_vld_q, s1_vld_d, s1_err_q, s1_err_d;
  logic [ID_W-1:0]   s1_owner_q, s1_owner_d;
  logic              s2_vld_q, s2_vld_d, s2_err_q, s2_err_d;
  logic [ID_W-1:0]   s2_owner_q, s2_owner_d;

  logic              grant_vld;
  logic              prio_hit;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_err;

  always_comb begin
    grant_vld  = 1'b0;
    prio_hit   = 1'b0;
    grant_idx  = '0;
    cand       = '0;
    grant_addr = '0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      grant_vld = 1'b1;
      prio_hit  = 1'b1;
    end
`endif
    // Rotating search from rr_ptr; requester 0 never matches here when it already won on priority.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_vld && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
    grant_err = ({1'b0, grant_addr} >= DEPTH);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld && !prio_hit) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    // Address and owner hold through idle cycles so the ROM bus does not toggle.
    s1_vld_d   = grant_vld;
    s1_err_d   = grant_vld && grant_err;
    s1_owner_d = grant_vld ? grant_idx : s1_owner_q;
    rom_addr_d = rom_addr_q;
    if (grant_vld) rom_addr_d = grant_err ? '0 : grant_addr;
    s2_vld_d   = s1_vld_q;
    s2_err_d   = s1_err_q;
    s2_owner_d = s1_owner_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rr_ptr_q   <= '0;
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_owner_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_owner_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_err_q   <= s1_err_d;
      s1_owner_q <= s1_owner_d;
      s2_vld_q   <= s2_vld_d;
      s2_err_q   <= s2_err_d;
      s2_owner_q <= s2_owner_d;
    end
  end

  assign bus.req_ready = (Reset_n && grant_vld) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.rsp_valid = (Reset_n && s2_vld_q) ? (NUM_REQ'(1) << s2_owner_q) : '0;
  assign bus.rsp_data  = (Reset_n && s2_vld_q && !s2_err_q) ? rom_data : '0;
  assign addr_err      = Reset_n && s2_vld_q && s2_err_q;
  assign rom_addr      = rom_addr_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized scoreboard bench for sprite_rom_arbiter against a rule-level arbitration and ROM model.
module tb_sprite_rom_arbiter;
  localparam int N     = 4;
  localparam int AW    = 19;
  localparam int DW    = 4;
  localparam int DEPTH = 122880;

  logic          Clk;
  logic          Reset_n;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          addr_err;

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus),
    .rom_addr(rom_addr), .rom_data(rom_data), .addr_err(addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[18:15] ^ 4'h5;
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int cyc);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          owner;
    logic [DW-1:0] data;
    bit          err;
  } rsp_t;

  rsp_t          sb[$];
  int            cyc = 0;
  int            ptr_m = 0;
  logic [AW-1:0] exp_rom = '0;

  always @(negedge Clk) begin
    logic [N-1:0]  exp_v, exp_rdy;
    logic [DW-1:0] exp_d;
    logic          exp_e;
    logic [AW-1:0] a;
    int            win;
    rsp_t          e;
    chk("rom_addr", 32'(rom_addr), 32'(exp_rom), cyc);
    if (!Reset_n) begin
      chk("reset_ready", 32'(bus.req_ready), 0, cyc);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 0, cyc);
      chk("reset_rsp_data", 32'(bus.rsp_data), 0, cyc);
      chk("reset_addr_err", 32'(addr_err), 0, cyc);
      sb.delete();
      ptr_m   = 0;
      exp_rom = '0;
    end else begin
      exp_v = '0; exp_d = '0; exp_e = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e     = sb.pop_front();
        exp_v = N'(1) << e.owner;
        exp_d = e.data;
        exp_e = e.err;
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v), cyc);
      chk("rsp_data", 32'(bus.rsp_data), 32'(exp_d), cyc);
      chk("addr_err", 32'(addr_err), 32'(exp_e), cyc);

      win = -1;
`ifdef SPRITE_ARB_PRIO0_EN
      if (bus.req_valid[0]) win = 0;
`endif
      for (int k = 0; k < N; k++) begin
        if (win < 0 && bus.req_valid[(ptr_m + k) % N]) win = (ptr_m + k) % N;
      end
      exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy), cyc);
      if (win >= 0) begin
        a = bus.req_addr[win*AW +: AW];
        e.due   = cyc + 2;
        e.owner = win;
        e.err   = (int'(a) >= DEPTH);
        e.data  = e.err ? '0 : rom_fn(a);
        sb.push_back(e);
        exp_rom = e.err ? '0 : a;
`ifdef SPRITE_ARB_PRIO0_EN
        if (win != 0) ptr_m = (win + 1) % N;
`else
        ptr_m = (win + 1) % N;
`endif
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] acc = '0;

  task automatic step();
    @(negedge Clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [AW-1:0] gen_addr(int i, int mode);
    int r;
    if (mode == 0) return AW'(100 + i);
    r = $urandom_range(0, 15);
    if (r == 0) return AW'(DEPTH);
    if (r == 1) return AW'(DEPTH - 1);
    if (r == 2) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Requesters in en that are idle or just accepted may raise a new request; pending ones hold.
  task automatic rand_cycles(int n, int pct, int mode, logic [N-1:0] en);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          if (en[i] && int'($urandom_range(0, 99)) < pct) begin
            bus.req_valid[i] = 1'b1;
            bus.req_addr[i*AW +: AW] = gen_addr(i, mode);
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      step();
    end
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) if (acc[i] || !bus.req_valid[i]) bus.req_valid[i] = 1'b0;
      step();
    end
  endtask

  task automatic issue_one(int i, logic [AW-1:0] a);
    int n = 0;
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    do begin
      step();
      n++;
    end while (!acc[i] && n < 16);
    checks++;
    if (!acc[i]) begin
      errors++;
      $display("FAIL issue_timeout: requester %0d not accepted after %0d cycles", i, n);
    end
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic reset_cycles(int n);
    Reset_n = 1'b0;
    for (int c = 0; c < n; c++) step();
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    reset_cycles(3);
    idle(2);

    issue_one(1, 19'h00123);
    idle(3);

    rand_cycles(8, 100, 0, 4'b1111);
    idle(4);

    issue_one(3, 19'd122880);
    idle(2);
    issue_one(3, 19'd122879);
    idle(3);

    rand_cycles(5, 100, 1, 4'b1111);
    reset_cycles(2);
    rand_cycles(6, 100, 1, 4'b1111);
    idle(4);

    issue_one(2, 19'h01abc);
    idle(3);
    issue_one(0, 19'h00007);
    idle(4);

    reset_cycles(1);
    rand_cycles(4, 100, 0, 4'b1111);
    rand_cycles(4, 100, 0, 4'b1110);
    idle(4);

    rand_cycles(400, 60, 1, 4'b1111);
    rand_cycles(200, 25, 1, 4'b1111);
    rand_cycles(20, 100, 1, 4'b1111);
    reset_cycles(1);
    rand_cycles(100, 80, 1, 4'b1111);
    idle(6);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
